// File: rtl/mips_muldiv_pkg.sv
// Shared op codes, FSM state codes and op classification helpers for the MIPS HI/LO unit.
package mips_muldiv_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_MULT  = 3'd0;
  localparam op_t OP_MULTU = 3'd1;
  localparam op_t OP_DIV   = 3'd2;
  localparam op_t OP_DIVU  = 3'd3;
  localparam op_t OP_MTHI  = 3'd4;
  localparam op_t OP_MTLO  = 3'd5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIX  = 2'd2;

  function automatic logic is_long_op(input op_t op);
    return op <= OP_DIVU;
  endfunction

  function automatic logic is_div_op(input op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One combinational iteration block: BITS shift-add (multiply) or restoring-subtract (divide) steps.
module mips_muldiv_step #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BITS  = 1
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH-1:0] rem_v;
  logic [WIDTH-1:0] quo_v;
  logic [WIDTH:0]   trial;

  // Multiply: {rem,quo} is the product/multiplier pair shifted right, LSB first.
  // Divide: {rem,quo} is the partial remainder/dividend pair shifted left, MSB first.
  always_comb begin
    rem_v = rem_in;
    quo_v = quo_in;
    trial = '0;
    for (int unsigned j = 0; j < BITS; j++) begin
      if (is_div) begin
        trial = {rem_v, quo_v[WIDTH-1]};
        quo_v = {quo_v[WIDTH-2:0], 1'b0};
        if (trial >= {1'b0, divisor}) begin
          trial    = trial - {1'b0, divisor};
          quo_v[0] = 1'b1;
        end
        rem_v = trial[WIDTH-1:0];
      end else begin
        trial = {1'b0, rem_v} + (quo_v[0] ? {1'b0, divisor} : {(WIDTH+1){1'b0}});
        quo_v = {trial[0], quo_v[WIDTH-1:1]};
        rem_v = trial[WIDTH:1];
      end
    end
    rem_out = rem_v;
    quo_out = quo_v;
  end

endmodule

// File: rtl/mips_muldiv_seq.sv
// Sequential MIPS multiply/divide unit with architectural HI/LO registers.
module mips_muldiv_seq
  import mips_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  op_t              op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             neg_lo, neg_lo_d, neg_hi, neg_hi_d;
  logic             busy_d, done_d, dbz_d;

  logic             sgn;
  logic [WIDTH-1:0] mag_a, mag_b, step_rem, step_quo, rem_fix, quo_fix;
  logic [PW-1:0]    prod_fix;

  mips_muldiv_step #(
    .WIDTH (WIDTH),
    .BITS  (BITS_PER_CYCLE)
  ) u_step (
    .is_div  (is_div_op(op_q)),
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Operands are registered raw so the negate path stays off the input ports.
  assign sgn      = is_signed_op(op_q);
  assign mag_a    = (sgn && a_q[WIDTH-1]) ? WIDTH'(-a_q) : a_q;
  assign mag_b    = (sgn && b_q[WIDTH-1]) ? WIDTH'(-b_q) : b_q;
  assign prod_fix = neg_lo ? PW'(-{rem_q, quo_q}) : {rem_q, quo_q};
  assign quo_fix  = neg_lo ? WIDTH'(-quo_q) : quo_q;
  assign rem_fix  = neg_hi ? WIDTH'(-rem_q) : rem_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    neg_lo_d = neg_lo;
    neg_hi_d = neg_hi;
    hi_d     = hi;
    lo_d     = lo;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (is_long_op(op)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            op_d    = op;
            a_d     = op_a;
            b_d     = op_b;
          end else if (op == OP_MTHI) begin
            hi_d   = op_a;
            done_d = 1'b1;
          end else if (op == OP_MTLO) begin
            lo_d   = op_a;
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        busy_d = 1'b1;
        cnt_d  = cnt + CNT_W'(1);
        if (cnt == '0) begin
          rem_d    = '0;
          quo_d    = mag_a;
          dvs_d    = mag_b;
          neg_lo_d = sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_hi_d = sgn & is_div_op(op_q) & a_q[WIDTH-1];
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          if (cnt == CNT_W'(STEPS)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
        if (is_div_op(op_q)) begin
          if (b_q == '0) begin
            dbz_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          hi_d = prod_fix[PW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      op_q        <= OP_MULT;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (clk_enable) begin
      state       <= state_d;
      cnt         <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_lo      <= neg_lo_d;
      neg_hi      <= neg_hi_d;
      hi          <= hi_d;
      lo          <= lo_d;
      busy        <= busy_d;
      done        <= done_d;
      div_by_zero <= dbz_d;
    end
  end

endmodule

// File: tb/tb_mips_muldiv_seq.sv
// Bench for mips_muldiv_seq: three instances (1, 2, 4 bits per cycle) driven in lockstep against an arithmetic model.
module tb_mips_muldiv_seq;
  import mips_muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, clk_enable, start;
  op_t          op;
  logic [W-1:0] op_a, op_b;
  logic [2:0]   busy, done, dbz;
  logic [W-1:0] hi [3];
  logic [W-1:0] lo [3];

  int total = 0;
  int bad   = 0;
  logic [W-1:0] m_hi, m_lo;

  typedef struct {
    op_t          o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
    logic         edbz;
  } vec_t;

  vec_t vecs [12];

  mips_muldiv_seq #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .op_a(op_a), .op_b(op_b), .busy(busy[0]), .done(done[0]), .div_by_zero(dbz[0]),
    .hi(hi[0]), .lo(lo[0]));
  mips_muldiv_seq #(.WIDTH(W), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .op_a(op_a), .op_b(op_b), .busy(busy[1]), .done(done[1]), .div_by_zero(dbz[1]),
    .hi(hi[1]), .lo(lo[1]));
  mips_muldiv_seq #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .op_a(op_a), .op_b(op_b), .busy(busy[2]), .done(done[2]), .div_by_zero(dbz[2]),
    .hi(hi[2]), .lo(lo[2]));

  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return int'(W) / (1 << i) + 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Architectural result from plain 64-bit arithmetic.
  task automatic model(input op_t o, input logic [W-1:0] a, input logic [W-1:0] b, output logic ex_dbz);
    longint     sa, sb, q, r;
    logic [63:0] p;
    ex_dbz = 1'b0;
    case (o)
      OP_MULT: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b == '0) ex_dbz = 1'b1;
        else if (o == OP_DIV) begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // kind: 0 ignored code, 1 move to HI/LO, 2 long op. Starts the op and watches every instance.
  task automatic observe(input string name, input int kind, input logic exp_dbz,
                         input int gap_at, input bit intrude);
    int first [3];
    int n_done [3];
    int n_busy [3];
    int n_dbz [3];
    int win;
    int exp_lat;
    win = 40 + ((gap_at >= 0) ? 5 : 0);
    for (int i = 0; i < 3; i++) begin
      first[i] = -1; n_done[i] = 0; n_busy[i] = 0; n_dbz[i] = 0;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t <= win; t++) begin
      if (t > 0) begin
        if (gap_at >= 0 && t == gap_at) clk_enable = 1'b0;
        if (gap_at >= 0 && t == gap_at + 5) clk_enable = 1'b1;
        if (intrude && t == 6) begin start = 1'b1; op = OP_DIVU; op_b = '0; end
        if (intrude && t == 7) start = 1'b0;
        tick();
      end
      for (int i = 0; i < 3; i++) begin
        if (done[i]) begin
          if (n_done[i] == 0) first[i] = t;
          n_done[i]++;
        end
        if (busy[i]) n_busy[i]++;
        if (dbz[i]) n_dbz[i]++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      exp_lat = (kind == 2) ? lat_of(i) + ((gap_at >= 0) ? 5 : 0) : 0;
      if (kind != 0) begin
        chk($sformatf("%s/latency[%0d]", name, i), 64'(first[i]), 64'(exp_lat));
        chk($sformatf("%s/done_pulses[%0d]", name, i), 64'(n_done[i]), 64'd1);
      end else begin
        chk($sformatf("%s/done_pulses[%0d]", name, i), 64'(n_done[i]), 64'd0);
      end
      chk($sformatf("%s/busy_cycles[%0d]", name, i), 64'(n_busy[i]),
          (kind == 2) ? 64'(exp_lat - 1) : 64'd0);
      chk($sformatf("%s/dbz[%0d]", name, i), 64'(n_dbz[i]), exp_dbz ? 64'd1 : 64'd0);
      chk($sformatf("%s/hi[%0d]", name, i), 64'(hi[i]), 64'(m_hi));
      chk($sformatf("%s/lo[%0d]", name, i), 64'(lo[i]), 64'(m_lo));
    end
  endtask

  initial begin
    logic         d;
    op_t          ro;
    logic [W-1:0] ra, rb;
    int           sel;

    reset = 1'b1; clk_enable = 1'b1; start = 1'b0;
    op = OP_MULT; op_a = '0; op_b = '0;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{OP_MTHI,  32'h00000011, 32'h0,        32'h00000011, 32'h80000000, 1'b0};
    vecs[5]  = '{OP_MTLO,  32'h00000022, 32'h0,        32'h00000011, 32'h00000022, 1'b0};
    vecs[6]  = '{OP_DIVU,  32'h00000007, 32'h0,        32'h00000011, 32'h00000022, 1'b1};
    vecs[7]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
    vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 1'b0};
    vecs[10] = '{OP_MTHI,  32'h00001234, 32'h0,        32'h00001234, 32'h0000000F, 1'b0};
    vecs[11] = '{3'd6,     32'h00000005, 32'h5,        32'h00001234, 32'h0000000F, 1'b0};

    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset/busy[%0d]", i), 64'(busy[i]), 64'd0);
      chk($sformatf("reset/done[%0d]", i), 64'(done[i]), 64'd0);
      chk($sformatf("reset/dbz[%0d]", i), 64'(dbz[i]), 64'd0);
      chk($sformatf("reset/hi[%0d]", i), 64'(hi[i]), 64'd0);
      chk($sformatf("reset/lo[%0d]", i), 64'(lo[i]), 64'd0);
    end
    reset = 1'b0;
    m_hi = '0; m_lo = '0;

    for (int k = 0; k < 12; k++) begin
      op = vecs[k].o; op_a = vecs[k].a; op_b = vecs[k].b;
      m_hi = vecs[k].ehi; m_lo = vecs[k].elo;
      observe($sformatf("vec%0d", k), (vecs[k].o <= OP_DIVU) ? 2 : (vecs[k].o <= OP_MTLO) ? 1 : 0,
              vecs[k].edbz, -1, 1'b0);
    end

    // A start arriving mid-operation must not disturb it.
    op = OP_MULT; op_a = 32'd6; op_b = 32'd7;
    model(OP_MULT, 32'd6, 32'd7, d);
    observe("intrude", 2, d, -1, 1'b1);

    // Five disabled cycles in the middle of a divide stretch latency by five.
    op = OP_DIV; op_a = 32'd100; op_b = 32'hFFFFFFF9;
    model(OP_DIV, 32'd100, 32'hFFFFFFF9, d);
    observe("enable_gap", 2, d, 8, 1'b0);

    // done holds while the clock enable is low.
    op = OP_MTLO; op_a = 32'h55; start = 1'b1;
    tick();
    start = 1'b0;
    m_lo = 32'h55;
    clk_enable = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold/done[%0d]", i), 64'(done[i]), 64'd1);
      chk($sformatf("hold/lo[%0d]", i), 64'(lo[i]), 64'(m_lo));
    end
    clk_enable = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) chk($sformatf("hold_release/done[%0d]", i), 64'(done[i]), 64'd0);

    // Reset in the middle of a multiply aborts it and clears HI/LO.
    op = OP_MULT; op_a = 32'h00012345; op_b = 32'h00000777; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort/busy[%0d]", i), 64'(busy[i]), 64'd0);
      chk($sformatf("abort/done[%0d]", i), 64'(done[i]), 64'd0);
      chk($sformatf("abort/hi[%0d]", i), 64'(hi[i]), 64'd0);
      chk($sformatf("abort/lo[%0d]", i), 64'(lo[i]), 64'd0);
    end
    op = OP_DIVU; op_a = 32'd1000; op_b = 32'd3;
    model(OP_DIVU, 32'd1000, 32'd3, d);
    observe("after_reset", 2, d, -1, 1'b0);

    for (int n = 0; n < 600; n++) begin
      ro  = op_t'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = '0;
      else if (sel == 1) rb = W'($urandom_range(1, 15));
      else if (sel == 2) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      else if (sel == 3) ra = W'($urandom_range(0, 255));
      op = ro; op_a = ra; op_b = rb;
      model(ro, ra, rb, d);
      observe($sformatf("rnd%0d", n), (ro <= OP_DIVU) ? 2 : (ro <= OP_MTLO) ? 1 : 0, d, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
